// File: rtl/dcnn_io_pkg.sv
// Shared types and constants for the DCNN I/O front end.
// Optional macro PIXEL_FULL_SCALE_EN selects 8'hFF instead of 8'h01 for "one" pixels.
package dcnn_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PARAM = 2'd1,
        IMAGE = 2'd2
    } state_t;

    localparam int         WORD_CYCLES = 34;
    localparam int         MAX_RUN     = 16;
    localparam logic [3:0] NO_RESULT   = 4'hF;

`ifdef PIXEL_FULL_SCALE_EN
    localparam logic [7:0] ONE_PIXEL = 8'hFF;
`else
    localparam logic [7:0] ONE_PIXEL = 8'h01;
`endif

endpackage

// File: rtl/rle_decompressor.sv
// Expands one run-length word (zeros count, ones count) per fixed slot into pixel writes.
// Pixel value for "one" comes from dcnn_io_pkg (PIXEL_FULL_SCALE_EN).
module rle_decompressor
    import dcnn_io_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WORD_CYCLES = dcnn_io_pkg::WORD_CYCLES,
    parameter int MAX_RUN     = dcnn_io_pkg::MAX_RUN
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic              active,
    input  logic [15:0]       din,
    input  logic [ADDR_W-1:0] base,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    localparam int SLOT_W = $clog2(WORD_CYCLES);
    localparam int RUN_W  = $clog2(MAX_RUN + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORD_CYCLES - 1);

    logic [SLOT_W-1:0] slot_reg;
    logic [RUN_W-1:0]  zero_left_reg;
    logic [RUN_W-1:0]  one_left_reg;
    logic [ADDR_W-1:0] ptr_reg;

    function automatic logic [RUN_W-1:0] clamp_run(input logic [7:0] v);
        if (v > 8'(MAX_RUN)) begin
            return RUN_W'(MAX_RUN);
        end
        return RUN_W'(v);
    endfunction

    // Slot 0 only latches the run lengths; pixels go out from slot 1 onward.
    assign we   = active && (slot_reg != '0) &&
                  ((zero_left_reg != '0) || (one_left_reg != '0));
    assign addr = ptr_reg;
    assign data = (zero_left_reg != '0) ? 8'h00 : ONE_PIXEL;

    always_ff @(posedge clk) begin
        if (srst) begin
            slot_reg      <= '0;
            zero_left_reg <= '0;
            one_left_reg  <= '0;
            ptr_reg       <= '0;
        end else if (start) begin
            slot_reg      <= '0;
            zero_left_reg <= '0;
            one_left_reg  <= '0;
            ptr_reg       <= base;
        end else if (active) begin
            slot_reg <= (slot_reg == SLOT_LAST) ? '0 : slot_reg + 1'b1;
            if (slot_reg == '0) begin
                zero_left_reg <= clamp_run(din[15:8]);
                one_left_reg  <= clamp_run(din[7:0]);
            end else if (zero_left_reg != '0) begin
                zero_left_reg <= zero_left_reg - 1'b1;
                ptr_reg       <= ptr_reg + 1'b1;
            end else if (one_left_reg != '0) begin
                one_left_reg <= one_left_reg - 1'b1;
                ptr_reg      <= ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcnn_io_coordinator.sv
// DCNN I/O front end: byte RAM loaded by host bytes, parameter words or RLE image words.
// Build option PIXEL_FULL_SCALE_EN (see dcnn_io_pkg) sets the "one" pixel value.
module dcnn_io_coordinator
    import dcnn_io_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                WORD_CYCLES = dcnn_io_pkg::WORD_CYCLES,
    parameter int                MAX_RUN     = dcnn_io_pkg::MAX_RUN,
    parameter logic [ADDR_W-1:0] RESULT_ADDR = '1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              interrupt,
    input  logic              load,
    input  logic              cnn,
    input  logic [15:0]       Din,
    output logic [3:0]        Dout,
    input  logic [ADDR_W-1:0] ramAddress,
    input  logic [7:0]        ramDataIn,
    output logic [7:0]        ramDataOut,
    input  logic              readSignal,
    input  logic              writeSignal
);

    logic [7:0] ram [0:(2**ADDR_W)-1];

    state_t            state_reg, state_next;
    logic              phase_reg;
    logic [3:0]        dout_reg;
    logic [7:0]        read_data_reg;
    logic              param_active, image_active, image_start;
    logic              rle_we;
    logic [ADDR_W-1:0] rle_addr;
    logic [7:0]        rle_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    // A mode only does work while load and cnn still select it.
    assign param_active = (state_reg == PARAM) && load && cnn;
    assign image_active = (state_reg == IMAGE) && load && !cnn;
    assign image_start  = (state_reg == IDLE) && load && !cnn;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = cnn ? PARAM : IMAGE;
            PARAM:   if (!load || !cnn) state_next = IDLE;
            IMAGE:   if (!load || cnn) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_reg <= IDLE;
            phase_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= param_active ? ~phase_reg : 1'b0;
        end
    end

    rle_decompressor #(
        .ADDR_W      (ADDR_W),
        .WORD_CYCLES (WORD_CYCLES),
        .MAX_RUN     (MAX_RUN)
    ) u_rle (
        .clk    (clk),
        .srst   (RST),
        .start  (image_start),
        .active (image_active),
        .din    (Din),
        .base   (ramAddress),
        .we     (rle_we),
        .addr   (rle_addr),
        .data   (rle_data)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ramAddress;
        wr_data = ramDataIn;
        if (!RST) begin
            if ((state_reg == IDLE) && writeSignal) begin
                wr_en = 1'b1;
            end else if (param_active) begin
                wr_en   = 1'b1;
                wr_addr = phase_reg ? ramAddress + ADDR_W'(1) : ramAddress;
                wr_data = phase_reg ? Din[7:0] : Din[15:8];
            end else if (image_active && rle_we) begin
                wr_en   = 1'b1;
                wr_addr = rle_addr;
                wr_data = rle_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Registered reads see the byte as it was before any same-cycle write.
    always_ff @(posedge clk) begin
        if (RST) begin
            read_data_reg <= 8'h00;
        end else if (readSignal) begin
            read_data_reg <= ram[ramAddress];
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            dout_reg <= NO_RESULT;
        end else if ((state_reg == IDLE) && load) begin
            dout_reg <= NO_RESULT;
        end else if ((state_reg == IDLE) && interrupt) begin
            dout_reg <= ram[RESULT_ADDR][3:0];
        end
    end

    assign Dout       = dout_reg;
    assign ramDataOut = read_data_reg;

endmodule

// File: tb/tb_dcnn_io_coordinator.sv
// Randomized bench for dcnn_io_coordinator with a transaction-level byte-RAM model.
module tb_dcnn_io_coordinator;

`ifdef PIXEL_FULL_SCALE_EN
    localparam logic [7:0] ONE_VAL = 8'hFF;
`else
    localparam logic [7:0] ONE_VAL = 8'h01;
`endif

    logic        clk = 1'b0;
    logic        RST, interrupt, load, cnn, readSignal, writeSignal;
    logic [15:0] Din, ramAddress;
    logic [7:0]  ramDataIn, ramDataOut;
    logic [3:0]  Dout;

    logic [7:0]  model_ram [0:65535];
    int          touched[$];
    logic [15:0] word_q[$];
    int          total = 0;
    int          bad = 0;

    dcnn_io_coordinator dut (
        .clk         (clk),
        .RST         (RST),
        .interrupt   (interrupt),
        .load        (load),
        .cnn         (cnn),
        .Din         (Din),
        .Dout        (Dout),
        .ramAddress  (ramAddress),
        .ramDataIn   (ramDataIn),
        .ramDataOut  (ramDataOut),
        .readSignal  (readSignal),
        .writeSignal (writeSignal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [15:0] a, input logic [7:0] d);
        writeSignal = 1'b1;
        ramAddress  = a;
        ramDataIn   = d;
        tick();
        writeSignal  = 1'b0;
        model_ram[a] = d;
        touched.push_back(int'(a));
        $display("write  addr=%04h data=%02h", a, d);
    endtask

    task automatic read_byte(input logic [15:0] a, output logic [7:0] d);
        readSignal = 1'b1;
        ramAddress = a;
        tick();
        d          = ramDataOut;
        readSignal = 1'b0;
    endtask

    task automatic verify_touched(input string tag);
        logic [7:0]  d;
        logic [15:0] a;
        while (touched.size() > 0) begin
            a = 16'(touched.pop_front());
            read_byte(a, d);
            $display("read   addr=%04h data=%02h exp=%02h", a, d, model_ram[a]);
            check(tag, {24'h0, d}, {24'h0, model_ram[a]});
        end
    endtask

    // Each word: 2 cycles, high byte at base+2k, low byte at base+2k+1.
    task automatic param_words(input logic [15:0] base, input bit keep_load);
        logic [15:0] a;
        load = 1'b1;
        cnn  = 1'b1;
        tick();
        for (int k = 0; k < word_q.size(); k++) begin
            a          = base + 16'(2 * k);
            ramAddress = a;
            Din        = word_q[k];
            tick();
            tick();
            model_ram[a]          = word_q[k][15:8];
            model_ram[a + 16'd1]  = word_q[k][7:0];
            touched.push_back(int'(a));
            touched.push_back(int'(a + 16'd1));
            $display("param  addr=%04h word=%04h", a, word_q[k]);
        end
        if (!keep_load) begin
            load = 1'b0;
            tick();
        end
    endtask

    task automatic image_run(input logic [15:0] base, input bit from_param);
        logic [15:0] ptr;
        logic [15:0] wa[$];
        logic [7:0]  wv[$];
        int          z, o;
        ptr = base;
        foreach (word_q[k]) begin
            z = (word_q[k][15:8] > 8'd16) ? 16 : int'(word_q[k][15:8]);
            o = (word_q[k][7:0] > 8'd16) ? 16 : int'(word_q[k][7:0]);
            for (int i = 0; i < z + o; i++) begin
                wa.push_back(ptr);
                wv.push_back((i < z) ? 8'h00 : ONE_VAL);
                ptr = ptr + 16'd1;
            end
        end
        if (!from_param) host_write(ptr, 8'hC6);
        ramAddress = base;
        load       = 1'b1;
        cnn        = 1'b0;
        Din        = word_q[0];
        if (from_param) tick();
        tick();
        foreach (word_q[k]) begin
            Din        = word_q[k];
            ramAddress = 16'($urandom);
            repeat (34) tick();
            $display("image  word=%04h", word_q[k]);
        end
        load = 1'b0;
        tick();
        foreach (wa[i]) begin
            model_ram[wa[i]] = wv[i];
            touched.push_back(int'(wa[i]));
        end
        if (!from_param) touched.push_back(int'(ptr));
    endtask

    initial begin
        logic [7:0]  d, v;
        logic [15:0] b, b2;

        RST = 1'b1; interrupt = 1'b0; load = 1'b0; cnn = 1'b0;
        Din = '0; ramAddress = '0; ramDataIn = '0;
        readSignal = 1'b0; writeSignal = 1'b0;
        repeat (3) tick();
        check("rst_dout", {28'h0, Dout}, 32'hF);
        check("rst_rdata", {24'h0, ramDataOut}, 32'h0);
        RST = 1'b0;
        tick();

        host_write(16'd0, 8'd1);
        host_write(16'd1, 8'd3);
        host_write(16'd2, 8'h00);
        host_write(16'd3, 8'h0E);
        host_write(16'd4, 8'h00);
        host_write(16'd5, 8'h5A);
        read_byte(16'd3, d);
        check("rd3", {24'h0, d}, 32'h0E);
        check("idle_dout", {28'h0, Dout}, 32'hF);
        for (int i = 0; i < 8; i++) host_write(16'h0200 + 16'($urandom_range(0, 255)), 8'($urandom));
        verify_touched("host_rd");

        host_write(16'h0350, 8'h11);
        writeSignal = 1'b1; readSignal = 1'b1; ramAddress = 16'h0350; ramDataIn = 8'h22;
        tick();
        writeSignal = 1'b0; readSignal = 1'b0;
        check("rdw_old", {24'h0, ramDataOut}, 32'h11);
        model_ram[16'h0350] = 8'h22;
        verify_touched("rdw_new");

        word_q = '{16'hA5C3, 16'h0102};
        param_words(16'd14, 1'b0);
        verify_touched("param_fixed");
        word_q.delete();
        for (int i = 0; i < 6; i++) word_q.push_back(16'($urandom));
        param_words(16'($urandom_range(16'h1000, 16'h1FFF)), 1'b0);
        word_q = '{16'($urandom)};
        param_words(16'hFFFF, 1'b0);
        verify_touched("param_rand");

        word_q = '{16'h0302, 16'h2814};
        image_run(16'd100, 1'b0);
        verify_touched("image_fixed");
        word_q.delete();
        for (int i = 0; i < 5; i++)
            word_q.push_back({8'($urandom_range(0, 40)), 8'($urandom_range(0, 40))});
        image_run(16'($urandom_range(16'h2000, 16'h2FFF)), 1'b0);
        verify_touched("image_rand");
        word_q = '{16'h0808};
        image_run(16'hFFF8, 1'b0);
        verify_touched("image_wrap");

        word_q = '{16'($urandom)};
        param_words(16'h3000, 1'b1);
        word_q = '{16'h0405};
        image_run(16'h3100, 1'b1);
        verify_touched("mode_switch");

        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 8'h07 : 8'($urandom);
            host_write(16'hFFFF, v);
            interrupt = 1'b1;
            tick();
            interrupt = 1'b0;
            check("dout_result", {28'h0, Dout}, {28'h0, v[3:0]});
            tick();
            check("dout_hold", {28'h0, Dout}, {28'h0, v[3:0]});
            load = 1'b1; cnn = i[0];
            tick();
            load = 1'b0;
            check("dout_enter", {28'h0, Dout}, 32'hF);
            tick();
            $display("result iter=%0d byte=%02h dout=%h", i, v, Dout);
        end
        load = 1'b1; cnn = 1'b1;
        tick();
        interrupt = 1'b1; ramAddress = 16'h0300; Din = 16'($urandom);
        tick();
        model_ram[16'h0300] = Din[15:8];
        touched.push_back(32'h0300);
        interrupt = 1'b0; load = 1'b0;
        tick();
        check("irq_in_param", {28'h0, Dout}, 32'hF);
        verify_touched("irq_param_wr");

        b  = 16'h0500;
        b2 = 16'h0600;
        for (int i = 0; i < 5; i++) host_write(b + 16'(i), 8'h77);
        for (int i = 5; i < 10; i++) host_write(b + 16'(i), 8'h3C);
        ramAddress = b; load = 1'b1; cnn = 1'b0; Din = 16'h000A;
        tick();
        repeat (5) tick();
        readSignal = 1'b1; ramAddress = b + 16'd5;
        tick();
        readSignal = 1'b0;
        check("rd_before_rst", {24'h0, ramDataOut}, 32'h3C);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_rdata", {24'h0, ramDataOut}, 32'h0);
        check("midrst_dout", {28'h0, Dout}, 32'hF);
        ramAddress = b2; Din = 16'h0102;
        tick();
        ramAddress = 16'h7777;
        repeat (34) tick();
        load = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) model_ram[b + 16'(i)] = ONE_VAL;
        model_ram[b2] = 8'h00;
        model_ram[b2 + 16'd1] = ONE_VAL;
        model_ram[b2 + 16'd2] = ONE_VAL;
        touched.delete();
        for (int i = 0; i < 10; i++) touched.push_back(int'(b) + i);
        for (int i = 0; i < 3; i++) touched.push_back(int'(b2) + i);
        verify_touched("midrst_ram");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
